// File: rtl/ast_width_reducer.sv
// Avalon-ST width reducer: splits each wide input beat into up to RATIO
// narrow output words, low word first, preserving sop/eop, channel and
// byte-exact empty. One input beat is buffered; the next beat is accepted
// in the same cycle the last word of the current beat leaves.
module ast_width_reducer #(
    parameter int DATA_IN_W   = 128,
    parameter int DATA_OUT_W  = 64,
    parameter int CHANNEL_W   = 10,
    parameter int EMPTY_IN_W  = ($clog2(DATA_IN_W / 8) < 1) ? 1 : $clog2(DATA_IN_W / 8),
    parameter int EMPTY_OUT_W = ($clog2(DATA_OUT_W / 8) < 1) ? 1 : $clog2(DATA_OUT_W / 8)
) (
    input  logic                   clk_i,
    input  logic                   srst_n_i,
    input  logic [DATA_IN_W-1:0]   ast_data_i,
    input  logic                   ast_startofpacket_i,
    input  logic                   ast_endofpacket_i,
    input  logic                   ast_valid_i,
    input  logic [EMPTY_IN_W-1:0]  ast_empty_i,
    input  logic [CHANNEL_W-1:0]   ast_channel_i,
    output logic                   ast_ready_o,
    output logic [DATA_OUT_W-1:0]  ast_data_o,
    output logic                   ast_startofpacket_o,
    output logic                   ast_endofpacket_o,
    output logic                   ast_valid_o,
    output logic [EMPTY_OUT_W-1:0] ast_empty_o,
    output logic [CHANNEL_W-1:0]   ast_channel_o,
    input  logic                   ast_ready_i
);

    localparam int RATIO = DATA_IN_W / DATA_OUT_W;
    localparam int IB    = DATA_IN_W / 8;
    localparam int OB    = DATA_OUT_W / 8;
    localparam int IDX_W = $clog2(RATIO);

    typedef enum logic {S_EMPTY, S_SEND} state_t;

    state_t                               state_q, state_d;
    logic [RATIO-1:0][DATA_OUT_W-1:0]     data_q, data_d;
    logic                                 sop_q, sop_d;
    logic                                 eop_q, eop_d;
    logic [CHANNEL_W-1:0]                 chan_q, chan_d;
    logic [IDX_W-1:0]                     idx_q, idx_d;
    logic [IDX_W-1:0]                     last_q, last_d;
    logic [EMPTY_OUT_W-1:0]               empty_q, empty_d;

    logic in_send;
    logic is_last;
    logic accept;
    logic out_xfer;
    logic load;

    // Index of the final word carrying valid bytes for this beat.
    function automatic logic [IDX_W-1:0] calc_last(input logic eop,
                                                   input logic [EMPTY_IN_W-1:0] emp);
        int v;
        if (!eop) return IDX_W'(RATIO - 1);
        v = IB - int'(emp);
        return IDX_W'((v - 1) / OB);
    endfunction

    // Unused upper bytes within the final output word of an eop beat.
    function automatic logic [EMPTY_OUT_W-1:0] calc_empty(input logic eop,
                                                          input logic [EMPTY_IN_W-1:0] emp);
        int v;
        int l;
        if (!eop) return '0;
        v = IB - int'(emp);
        l = (v - 1) / OB;
        return EMPTY_OUT_W'((l + 1) * OB - v);
    endfunction

    assign in_send  = (state_q == S_SEND);
    assign is_last  = (idx_q == last_q);
    // Ready is combinational from ast_ready_i so a new beat slips in with no bubble.
    assign ast_ready_o = srst_n_i & (~in_send | (is_last & ast_ready_i));
    assign accept   = ast_valid_i & ast_ready_o;
    assign out_xfer = in_send & ast_ready_i;

    assign ast_valid_o         = in_send;
    assign ast_data_o          = data_q[idx_q];
    assign ast_startofpacket_o = (idx_q == '0) & sop_q;
    assign ast_endofpacket_o   = is_last & eop_q;
    assign ast_empty_o         = (is_last & eop_q) ? empty_q : '0;
    assign ast_channel_o       = chan_q;

    // Next-state: walk the word index, reload on the last word or from EMPTY.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        chan_d  = chan_q;
        idx_d   = idx_q;
        last_d  = last_q;
        empty_d = empty_q;
        load    = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    load    = 1'b1;
                    state_d = S_SEND;
                end
            end
            S_SEND: begin
                if (out_xfer) begin
                    if (!is_last) begin
                        idx_d = idx_q + IDX_W'(1);
                    end else if (accept) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_EMPTY;
                    end
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (load) begin
            data_d  = ast_data_i;
            sop_d   = ast_startofpacket_i;
            eop_d   = ast_endofpacket_i;
            chan_d  = ast_channel_i;
            idx_d   = '0;
            last_d  = calc_last(ast_endofpacket_i, ast_empty_i);
            empty_d = calc_empty(ast_endofpacket_i, ast_empty_i);
        end
    end

    // State and beat buffer; reset clears everything so outputs read as zero.
    always_ff @(posedge clk_i) begin
        if (!srst_n_i) begin
            state_q <= S_EMPTY;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            chan_q  <= '0;
            idx_q   <= '0;
            last_q  <= '0;
            empty_q <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            chan_q  <= chan_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            empty_q <= empty_d;
        end
    end

endmodule
